// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth partial-product accumulator.
// Sums N/2 shifted signed products and presents the 2N-bit result on valid/ready.
module booth_pp_accumulator #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pp_valid,
   output logic           pp_ready,
   input  logic [N+1:0]   pp_data,
   input  logic           flush,
   output logic           prod_valid,
   input  logic           prod_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int PP_COUNT = N / 2;
   localparam int IDX_W    = (PP_COUNT > 1) ? $clog2(PP_COUNT) : 1;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t           state;
   logic [2*N-1:0]   acc;
   logic [IDX_W-1:0] idx;

   logic [2*N-1:0]   sext;
   logic [2*N-1:0]   term;
   logic [2*N-1:0]   sum;
   logic             last;

   // Digit i carries weight 4^i, hence the shift by 2*idx.
   assign sext = {{(N-2){pp_data[N+1]}}, pp_data};
   assign term = sext << {idx, 1'b0};
   assign sum  = acc + term;
   assign last = (idx == IDX_W'(PP_COUNT - 1));

   assign pp_ready   = (state == ACCUM) && !reset;
   assign prod_valid = (state == DONE);
   assign busy       = (state == DONE) || (idx != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ACCUM;
         acc     <= '0;
         idx     <= '0;
         product <= '0;
      end else begin
         unique case (state)
            ACCUM: begin
               if (flush) begin
                  acc <= '0;
                  idx <= '0;
               end else if (pp_valid) begin
                  if (last) begin
                     product <= sum;
                     acc     <= '0;
                     idx     <= '0;
                     state   <= DONE;
                  end else begin
                     acc <= sum;
                     idx <= idx + 1'b1;
                  end
               end
            end
            DONE: begin
               if (prod_ready) state <= ACCUM;
            end
         endcase
      end
   end

endmodule
